// File: rtl/rc4_search_pkg.sv
// Shared key-search types: candidate key width, key-space limit and sequencer states.
package rc4_search_pkg;

  localparam int KEY_W = 22;
  localparam logic [KEY_W-1:0] MAX_KEY = 22'h3FFFFF;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FOUND,
    EXHAUSTED,
    STOPPED
  } seq_state_t;

endpackage

// File: rtl/search_watchdog.sv
// Per-candidate timeout: reloaded on clear, counts WAIT cycles, flags the last one.
module search_watchdog #(
  parameter int TIMEOUT = 4096,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter: remaining WAIT cycles before the relaunch cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/key_search_sequencer.sv
// Per-core brute-force key walker: launches the core once per candidate, strides by
// total_cores, stops on own hit, peer hit (global_stop) or key-space exhaustion.
//   state     | meaning
//   IDLE      | waiting for start
//   LAUNCH    | one-cycle core_restart pulse for secret_key
//   WAIT      | core evaluating; watchdog running
//   FOUND     | secret_key is the solution (terminal)
//   EXHAUSTED | subset searched without hit (terminal)
//   STOPPED   | a peer core found the key (terminal)
module key_search_sequencer #(
  parameter int KEY_W = rc4_search_pkg::KEY_W,
  parameter logic [KEY_W-1:0] MAX_KEY = rc4_search_pkg::MAX_KEY,
  parameter int STRIDE_W = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_W-1:0]    core_init_val,
  input  logic [STRIDE_W-1:0] total_cores,
  input  logic                core_done,
  input  logic                core_valid,
  input  logic                global_stop,
  output logic                core_restart,
  output logic [KEY_W-1:0]    secret_key,
  output logic                key_found,
  output logic                exhausted,
  output logic                busy,
  output logic [KEY_W-1:0]    keys_tried
);

  import rc4_search_pkg::*;

  localparam logic [KEY_W:0] LIMIT = {1'b0, MAX_KEY};

  seq_state_t           state_q, state_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [KEY_W-1:0]     tried_q, tried_d;
  logic [STRIDE_W-1:0]  stride_q, stride_d;
  logic [KEY_W:0]       next_key;
  logic                 wd_expire;

  // One extra bit so a carry out of KEY_W counts as past MAX_KEY, never as a wrap.
  assign next_key = {1'b0, key_q} + (KEY_W + 1)'(stride_q);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    tried_d  = tried_q;
    stride_d = stride_q;
    case (state_q)
      IDLE: begin
        if (start && !global_stop) begin
          key_d    = core_init_val;
          stride_d = (total_cores == '0) ? STRIDE_W'(1) : total_cores;
          tried_d  = '0;
          state_d  = (core_init_val > MAX_KEY) ? EXHAUSTED : LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (core_done && core_valid) begin
          state_d = FOUND;
        end else if (global_stop) begin
          state_d = STOPPED;
        end else if (core_done) begin
          if (tried_q != '1) begin
            tried_d = tried_q + 1'b1;
          end
          if (next_key > LIMIT) begin
            state_d = EXHAUSTED;
          end else begin
            key_d   = next_key[KEY_W-1:0];
            state_d = LAUNCH;
          end
        end else if (wd_expire) begin
          state_d = LAUNCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      key_q    <= '0;
      tried_q  <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      tried_q  <= tried_d;
      stride_q <= stride_d;
    end
  end

  search_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == LAUNCH),
    .run_i   (state_q == WAIT),
    .expire_o(wd_expire)
  );

  assign core_restart = (state_q == LAUNCH);
  assign busy         = (state_q == LAUNCH) || (state_q == WAIT);
  assign key_found    = (state_q == FOUND);
  assign exhausted    = (state_q == EXHAUSTED);
  assign secret_key   = key_q;
  assign keys_tried   = tried_q;

endmodule

// File: tb/tb_key_search_sequencer.sv
// Bench for key_search_sequencer (MAX_KEY=10): event-level reference model checked every
// cycle, plus literal expectations for launched key sequences, verdicts and latencies.
module tb_key_search_sequencer;

  localparam int KEY_W    = 22;
  localparam int STRIDE_W = 8;
  localparam int TIMEOUT  = 4096;
  localparam longint MAXK = 10;
  localparam longint SAT  = (longint'(1) << KEY_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [KEY_W-1:0]    core_init_val = '0;
  logic [STRIDE_W-1:0] total_cores = '0;
  logic                core_done = 1'b0;
  logic                core_valid = 1'b0;
  logic                global_stop = 1'b0;
  logic                core_restart;
  logic [KEY_W-1:0]    secret_key;
  logic                key_found;
  logic                exhausted;
  logic                busy;
  logic [KEY_W-1:0]    keys_tried;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_search_sequencer #(
    .MAX_KEY(22'd10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .core_init_val(core_init_val),
    .total_cores  (total_cores),
    .core_done    (core_done),
    .core_valid   (core_valid),
    .global_stop  (global_stop),
    .core_restart (core_restart),
    .secret_key   (secret_key),
    .key_found    (key_found),
    .exhausted    (exhausted),
    .busy         (busy),
    .keys_tried   (keys_tried)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: flags and integer arithmetic over the search rules.
  bit     m_live = 0, m_searching = 0, m_restart = 0, m_found = 0, m_exh = 0, m_stop = 0;
  longint m_key = 0, m_stride = 0, m_tried = 0, m_wait = 0;

  task automatic model_step();
    if (reset) begin
      m_live = 1; m_searching = 0; m_restart = 0; m_found = 0; m_exh = 0; m_stop = 0;
      m_key = 0; m_stride = 0; m_tried = 0; m_wait = 0;
    end else if (m_found || m_exh || m_stop) begin
      m_restart = 0;
    end else if (!m_searching) begin
      if (start && !global_stop) begin
        m_key    = longint'(core_init_val);
        m_stride = (total_cores == 0) ? 1 : longint'(total_cores);
        m_tried  = 0;
        if (m_key > MAXK) m_exh = 1;
        else begin m_searching = 1; m_restart = 1; end
      end
    end else if (m_restart) begin
      m_restart = 0;
      m_wait = 0;
    end else if (core_done && core_valid) begin
      m_found = 1; m_searching = 0;
    end else if (global_stop) begin
      m_stop = 1; m_searching = 0;
    end else if (core_done) begin
      if (m_tried < SAT) m_tried++;
      if (m_key + m_stride > MAXK) begin
        m_exh = 1; m_searching = 0;
      end else begin
        m_key = m_key + m_stride; m_restart = 1;
      end
    end else if (m_wait == TIMEOUT - 1) begin
      m_restart = 1;
    end else begin
      m_wait++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("core_restart", longint'(core_restart), longint'(m_restart));
      chk("busy",         longint'(busy),         longint'(m_searching));
      chk("key_found",    longint'(key_found),    longint'(m_found));
      chk("exhausted",    longint'(exhausted),    longint'(m_exh));
      chk("secret_key",   longint'(secret_key),   m_key);
      chk("keys_tried",   longint'(keys_tried),   m_tried);
    end
  end

  // Core stand-in: answers each restart two cycles later, valid only for valid_key.
  bit     resp_en = 0;
  int     resp_cnt = 0;
  longint valid_key = -1;
  longint log_key[$];
  int     log_cyc[$];
  int     cyc = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    core_done  = 1'b0;
    core_valid = 1'b0;
    if (core_restart) begin
      log_key.push_back(longint'(secret_key));
      log_cyc.push_back(cyc);
      resp_cnt = 2;
    end else if (resp_en && resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        core_done  = 1'b1;
        core_valid = (longint'(secret_key) == valid_key);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; global_stop = 1'b0; resp_en = 0; resp_cnt = 0;
    tick(); tick();
    reset = 1'b0;
    log_key.delete(); log_cyc.delete();
  endtask

  task automatic start_search(input int init, input int stride);
    core_init_val = KEY_W'(init);
    total_cores   = STRIDE_W'(stride);
    start = 1'b1;
  endtask

  task automatic wait_launches(input int n, input int budget, input string name);
    int k = 0;
    while (log_key.size() < n && k < budget) begin tick(); k++; end
    chk(name, longint'(log_key.size()), longint'(n));
  endtask

  task automatic wait_verdict(input int budget, input string name);
    int k = 0;
    while (!(key_found || exhausted) && k < budget) begin tick(); k++; end
    chk(name, longint'(key_found || exhausted), 1);
  endtask

  task automatic chk_log(input string name, input longint exp[$]);
    chk({name, "_count"}, longint'(log_key.size()), longint'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_key.size(); i++)
      chk($sformatf("%s_key%0d", name, i), log_key[i], exp[i]);
  endtask

  initial begin
    int c0;
    tick(); tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_key", longint'(secret_key), 0);

    // Single hit: 0, 2, 4 with 4 valid; start dropped mid-search.
    do_reset();
    resp_en = 1; valid_key = 4;
    start_search(0, 2);
    wait_launches(1, 5, "t1_first");
    start = 1'b0;
    wait_verdict(100, "t1_verdict");
    chk_log("t1", '{0, 2, 4});
    chk("t1_found", longint'(key_found), 1);
    chk("t1_key", longint'(secret_key), 4);
    chk("t1_tried", longint'(keys_tried), 2);
    chk("t1_busy", longint'(busy), 0);
    core_done = 1'b1; core_valid = 1'b0;
    repeat (3) tick();
    chk("t1_hold_tried", longint'(keys_tried), 2);

    // Exhaustion: 1, 5, 9; 13 is past MAX_KEY.
    do_reset();
    resp_en = 1; valid_key = -1;
    start_search(1, 4);
    wait_verdict(100, "t2_verdict");
    repeat (5) tick();
    chk_log("t2", '{1, 5, 9});
    chk("t2_exh", longint'(exhausted), 1);
    chk("t2_tried", longint'(keys_tried), 3);
    chk("t2_key", longint'(secret_key), 9);

    // Inclusive limit: 10 itself is launched.
    do_reset();
    resp_en = 1; valid_key = -1;
    start_search(2, 4);
    wait_verdict(100, "t3_verdict");
    chk_log("t3", '{2, 6, 10});
    chk("t3_exh", longint'(exhausted), 1);

    // Peer stop during WAIT on key 6.
    do_reset();
    resp_en = 1; valid_key = -1;
    start_search(2, 4);
    wait_launches(2, 20, "t4_launch6");
    resp_en = 0;
    tick();
    global_stop = 1'b1;
    tick();
    global_stop = 1'b0;
    chk("t4_busy", longint'(busy), 0);
    repeat (20) tick();
    chk_log("t4", '{2, 6});
    chk("t4_found", longint'(key_found), 0);
    chk("t4_exh", longint'(exhausted), 0);

    // global_stop in IDLE blocks launch; then collision of valid done with global_stop.
    do_reset();
    global_stop = 1'b1;
    start_search(3, 1);
    repeat (4) tick();
    chk("t5_idle_launches", longint'(log_key.size()), 0);
    global_stop = 1'b0;
    wait_launches(1, 5, "t5_launch");
    tick();
    core_done = 1'b1; core_valid = 1'b1; global_stop = 1'b1;
    tick();
    global_stop = 1'b0;
    tick();
    chk("t5_found", longint'(key_found), 1);
    chk("t5_key", longint'(secret_key), 3);
    chk("t5_tried", longint'(keys_tried), 0);

    // Timeout relaunch, then reset mid-WAIT and a fresh launch from the new init value.
    do_reset();
    start_search(5, 3);
    wait_launches(1, 5, "t6_first");
    wait_launches(2, TIMEOUT + 20, "t6_relaunch");
    if (log_key.size() >= 2) begin
      chk("t6_same_key", log_key[1], 5);
      chk("t6_period", longint'(log_cyc[1] - log_cyc[0]), TIMEOUT + 1);
    end
    chk("t6_tried", longint'(keys_tried), 0);
    repeat (10) tick();
    core_init_val = KEY_W'(8);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", longint'(busy), 0);
    chk("t6_rst_key", longint'(secret_key), 0);
    chk("t6_rst_restart", longint'(core_restart), 0);
    reset = 1'b0;
    log_key.delete(); log_cyc.delete();
    c0 = cyc;
    wait_launches(1, 5, "t6_fresh");
    if (log_key.size() >= 1) begin
      chk("t6_fresh_key", log_key[0], 8);
      chk("t6_fresh_latency", longint'(log_cyc[0] - c0), 1);
    end

    // Zero stride treated as one: 7, 8, 9 with 9 valid.
    do_reset();
    resp_en = 1; valid_key = 9;
    start_search(7, 0);
    wait_verdict(100, "t7_verdict");
    chk_log("t7", '{7, 8, 9});
    chk("t7_found", longint'(key_found), 1);
    chk("t7_key", longint'(secret_key), 9);

    // Initial value already past MAX_KEY.
    do_reset();
    start_search(11, 1);
    tick(); tick();
    chk("t8_exh", longint'(exhausted), 1);
    chk("t8_launches", longint'(log_key.size()), 0);
    chk("t8_busy", longint'(busy), 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule
